spike_pushback_sched: RTL and testbench

SPIKE_PUSHBACK_SCHED -- requirements
Module: spike_pushback_sched

---
 rtl/spike_pushback_sched.sv | 151 +++++++++++++++
 tb/tb_spike_pushback_sched.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_pushback_sched.sv
// Spike pushback scheduler: queues spikes found during a time-step neuron scan and
// merges them with external AER events onto one registered scheduler port.
module spike_pushback_sched #(
    parameter int unsigned M     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         scan_start_i,
    input  logic         scan_valid_i,
    input  logic         spike_i,
    input  logic [M-1:0] neuron_idx_i,
    input  logic         ext_req_i,
    input  logic [M-1:0] ext_addr_i,
    output logic         ext_gnt_o,
    output logic         evt_valid_o,
    output logic [M-1:0] evt_addr_o,
    output logic         evt_src_o,
    input  logic         evt_ready_i,
    output logic         scan_busy_o,
    output logic         fifo_full_o,
    output logic         overflow_o,
    output logic [M:0]   spike_cnt_o,
    output logic         inference_done_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

    state_t       state_q, state_d;
    logic         in_scan, scan_clear;

    logic [M-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr, rd_ptr;
    logic         fifo_empty, fifo_full;

    logic         out_valid, out_src;
    logic [M-1:0] out_addr;
    logic         last_ext;
    logic         load_en, sel_pb, sel_ext;

    logic         push_req, push_ok, drop;
    logic         overflow_q;
    logic [M:0]   cnt_q;

    // Extra pointer bit tells a full FIFO from an empty one when the indices match.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (scan_start_i) state_d = S_SCAN;
            S_SCAN:  if (scan_valid_i && (neuron_idx_i == '1)) state_d = S_DRAIN;
            S_DRAIN: if (fifo_empty && !(out_valid && out_src)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_scan          = (state_q == S_SCAN);
        scan_clear       = (state_q == S_IDLE) && scan_start_i;
        scan_busy_o      = (state_q != S_IDLE);
        inference_done_o = (state_q == S_DONE);
    end

    // Ties alternate on the last granted source; last_ext resets high so pushback wins first.
    always_comb begin
        load_en = !out_valid || evt_ready_i;
        sel_pb  = 1'b0;
        sel_ext = 1'b0;
        if (rst_ni && load_en) begin
            if (!fifo_empty && ext_req_i) begin
                sel_pb  = last_ext;
                sel_ext = !last_ext;
            end else begin
                sel_pb  = !fifo_empty;
                sel_ext = ext_req_i;
            end
        end
    end

    always_comb begin
        push_req = in_scan && scan_valid_i && spike_i;
        push_ok  = push_req && (!fifo_full || sel_pb);
        drop     = push_req && !push_ok;
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= neuron_idx_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (sel_pb)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_src   <= 1'b0;
            last_ext  <= 1'b1;
        end else if (load_en) begin
            out_valid <= sel_pb | sel_ext;
            if (sel_pb) begin
                out_addr <= mem[rd_ptr[AW-1:0]];
                out_src  <= 1'b1;
                last_ext <= 1'b0;
            end else if (sel_ext) begin
                out_addr <= ext_addr_i;
                out_src  <= 1'b0;
                last_ext <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || scan_clear) begin
            overflow_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            if (drop) overflow_q <= 1'b1;
            if (push_req && (cnt_q != '1)) cnt_q <= cnt_q + (M+1)'(1);
        end
    end

    assign ext_gnt_o   = sel_ext;
    assign evt_valid_o = out_valid;
    assign evt_addr_o  = out_addr;
    assign evt_src_o   = out_src;
    assign fifo_full_o = fifo_full;
    assign overflow_o  = overflow_q;
    assign spike_cnt_o = cnt_q;

endmodule

// File: tb/tb_spike_pushback_sched.sv
// Bench for spike_pushback_sched: hand-computed vector table, directed multi-cycle
// sequences, then random traffic against a queue-based reference model.
`timescale 1ns/1ps
module tb_spike_pushback_sched;
    localparam int M       = 8;
    localparam int DEPTH   = 4;
    localparam int CNT_MAX = (1 << (M + 1)) - 1;
    localparam int P_IDLE = 0, P_SCAN = 1, P_DRAIN = 2, P_DONE = 3;

    logic         clk;
    logic         rst_n, scan_start, scan_valid, spike, ext_req, ready;
    logic [M-1:0] idx, ext_addr, evt_addr;
    logic         gnt, evt_valid, evt_src, busy, full, ovf, done;
    logic [M:0]   cnt;

    spike_pushback_sched #(.M(M), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_ni(rst_n), .scan_start_i(scan_start), .scan_valid_i(scan_valid),
        .spike_i(spike), .neuron_idx_i(idx), .ext_req_i(ext_req), .ext_addr_i(ext_addr),
        .ext_gnt_o(gnt), .evt_valid_o(evt_valid), .evt_addr_o(evt_addr), .evt_src_o(evt_src),
        .evt_ready_i(ready), .scan_busy_o(busy), .fifo_full_o(full), .overflow_o(ovf),
        .spike_cnt_o(cnt), .inference_done_o(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: scan phase, spike queue, output slot, who won the last load.
    int mq[$];
    bit mv, ms, m_last_ext, movf;
    int ma, mphase, mcnt;
    bit model_on;

    function automatic void model_choice(output bit tp, output bit te);
        bit can;
        can = !mv || ready;
        tp = 1'b0;
        te = 1'b0;
        if (rst_n && can) begin
            if (mq.size() > 0 && ext_req) tp = m_last_ext;
            else tp = (mq.size() > 0);
            te = ext_req && !tp;
        end
    endfunction

    task automatic model_step();
        bit tp, te, was_scan;
        int np;
        if (!rst_n) begin
            mq.delete(); mv = 0; ma = 0; ms = 0; m_last_ext = 1;
            mphase = P_IDLE; movf = 0; mcnt = 0;
            return;
        end
        model_choice(tp, te);
        np = mphase;
        was_scan = (mphase == P_SCAN);
        case (mphase)
            P_IDLE:  if (scan_start) np = P_SCAN;
            P_SCAN:  if (scan_valid && idx == {M{1'b1}}) np = P_DRAIN;
            P_DRAIN: if (mq.size() == 0 && !(mv && ms)) np = P_DONE;
            default: np = P_IDLE;
        endcase
        if (mphase == P_IDLE && scan_start) begin movf = 0; mcnt = 0; end
        if (tp) begin ma = mq.pop_front(); ms = 1; mv = 1; m_last_ext = 0; end
        else if (te) begin ma = ext_addr; ms = 0; mv = 1; m_last_ext = 1; end
        else if (!mv || ready) mv = 0;
        if (was_scan && scan_valid && spike) begin
            if (mcnt < CNT_MAX) mcnt++;
            if (mq.size() < DEPTH) mq.push_back(int'(idx));
            else movf = 1;
        end
        mphase = np;
    endtask

    task automatic check_model();
        bit tp, te;
        model_choice(tp, te);
        check("evt_valid", evt_valid, mv);
        if (mv) begin
            check("evt_addr", evt_addr, ma);
            check("evt_src", evt_src, ms);
        end
        check("ext_gnt", gnt, te);
        check("scan_busy", busy, mphase != P_IDLE);
        check("fifo_full", full, mq.size() == DEPTH);
        check("overflow", ovf, movf);
        check("spike_cnt", cnt, mcnt);
        check("inference_done", done, mphase == P_DONE);
    endtask

    // DUT outputs sampled at the falling edge, used at the following rising edge.
    bit s_valid, s_src, s_done;
    int s_addr;
    int log_addr[$], log_src[$];
    int done_pulses = 0;

    task automatic probe();
        @(negedge clk);
        if (model_on) check_model();
        s_valid = evt_valid; s_addr = evt_addr; s_src = evt_src; s_done = done;
    endtask

    task automatic edge_step();
        @(posedge clk);
        if (rst_n && s_valid && ready) begin
            log_addr.push_back(s_addr);
            log_src.push_back(s_src);
        end
        if (s_done) done_pulses++;
        model_step();
        #1;
    endtask

    task automatic tick();
        probe();
        edge_step();
    endtask

    task automatic drive(input int r, st, sv, sp, ix, ex, ea, rd);
        rst_n = r[0]; scan_start = st[0]; scan_valid = sv[0]; spike = sp[0];
        idx = ix[M-1:0]; ext_req = ex[0]; ext_addr = ea[M-1:0]; ready = rd[0];
    endtask

    task automatic wait_done(input int budget, input string name);
        int start;
        start = done_pulses;
        for (int k = 0; k < budget && done_pulses == start; k++) tick();
        check(name, done_pulses - start, 1);
    endtask

    typedef struct {
        int r, st, sv, sp, ix, ex, ea, rd;
        int v, a, s, g, b, f, o, c, d;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(input int r, st, sv, sp, ix, ex, ea, rd,
                                input int v, a, s, g, b, f, o, c, d);
        vec_t t;
        t.r = r; t.st = st; t.sv = sv; t.sp = sp; t.ix = ix; t.ex = ex; t.ea = ea; t.rd = rd;
        t.v = v; t.a = a; t.s = s; t.g = g; t.b = b; t.f = f; t.o = o; t.c = c; t.d = d;
        return t;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // rst st sv sp idx ext ea rdy | valid addr src gnt busy full ovf cnt done
        tbl.push_back(mk(0,0,0,0,  0,1,8'h33,1, 0, 0,0,0,0,0,0,0,0));
        tbl.push_back(mk(1,1,0,0,  0,0,    0,0, 0, 0,0,0,0,0,0,0,0));
        tbl.push_back(mk(1,0,1,1, 10,0,    0,0, 0, 0,0,0,1,0,0,0,0));
        tbl.push_back(mk(1,0,1,1, 11,0,    0,0, 0, 0,0,0,1,0,0,1,0));
        tbl.push_back(mk(1,0,1,1, 12,0,    0,0, 1,10,1,0,1,0,0,2,0));
        tbl.push_back(mk(1,0,1,1, 13,0,    0,0, 1,10,1,0,1,0,0,3,0));
        tbl.push_back(mk(1,0,1,1, 14,0,    0,0, 1,10,1,0,1,0,0,4,0));
        tbl.push_back(mk(1,0,1,1, 15,0,    0,0, 1,10,1,0,1,1,0,5,0));
        tbl.push_back(mk(1,0,0,0,  0,1,8'h55,0, 1,10,1,0,1,1,1,6,0));
        tbl.push_back(mk(1,0,0,0,  0,1,8'h55,1, 1,10,1,1,1,1,1,6,0));
        tbl.push_back(mk(1,0,1,1, 16,1,8'h55,1, 1,8'h55,0,0,1,1,1,6,0));
        tbl.push_back(mk(1,0,0,0,  0,0,    0,0, 1,11,1,0,1,1,1,7,0));
        tbl.push_back(mk(1,0,1,0,255,0,    0,0, 1,11,1,0,1,1,1,7,0));
        tbl.push_back(mk(1,1,0,0,  0,0,    0,0, 1,11,1,0,1,1,1,7,0));
        tbl.push_back(mk(1,0,1,1, 20,0,    0,0, 1,11,1,0,1,1,1,7,0));
        tbl.push_back(mk(1,0,0,0,  0,0,    0,0, 1,11,1,0,1,1,1,7,0));

        model_on = 0;
        drive(0,0,0,0,0,0,0,0);
        repeat (2) tick();

        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].st, tbl[i].sv, tbl[i].sp, tbl[i].ix, tbl[i].ex, tbl[i].ea, tbl[i].rd);
            probe();
            check($sformatf("row%0d evt_valid", i), evt_valid, tbl[i].v);
            check($sformatf("row%0d evt_addr", i), evt_addr, tbl[i].a);
            check($sformatf("row%0d evt_src", i), evt_src, tbl[i].s);
            check($sformatf("row%0d ext_gnt", i), gnt, tbl[i].g);
            check($sformatf("row%0d scan_busy", i), busy, tbl[i].b);
            check($sformatf("row%0d fifo_full", i), full, tbl[i].f);
            check($sformatf("row%0d overflow", i), ovf, tbl[i].o);
            check($sformatf("row%0d spike_cnt", i), cnt, tbl[i].c);
            check($sformatf("row%0d inference_done", i), done, tbl[i].d);
            edge_step();
        end

        // Drain the backlog left by the table, then restart a scan from IDLE.
        model_on = 1;
        log_addr.delete(); log_src.delete();
        drive(1,0,0,0,0,0,0,1);
        wait_done(30, "039 drain done");
        check("039 drained count", log_addr.size(), 5);
        if (log_addr.size() == 5) begin
            check("039 drain addr0", log_addr[0], 11);
            check("039 drain addr4", log_addr[4], 16);
            check("039 drain src4", log_src[4], 1);
        end
        tick();
        probe();
        check("039 overflow kept in idle", ovf, 1);
        edge_step();
        drive(1,1,0,0,0,0,0,1);
        tick();
        drive(1,0,0,0,0,0,0,1);
        probe();
        check("039 overflow cleared", ovf, 0);
        check("039 count cleared", cnt, 0);
        check("039 busy", busy, 1);
        edge_step();

        // Full scan 0..255 with spikes at 3 and 200.
        drive(0,0,0,0,0,0,0,1);
        tick();
        drive(1,1,0,0,0,0,0,1);
        tick();
        log_addr.delete(); log_src.delete();
        begin
            int base;
            base = done_pulses;
            for (int i = 0; i < 256; i++) begin
                drive(1,0,1,(i == 3 || i == 200) ? 1 : 0, i, 0, 0, 1);
                tick();
            end
            drive(1,0,0,0,0,0,0,1);
            wait_done(20, "035 done");
            repeat (3) tick();
            check("035 done pulses", done_pulses - base, 1);
        end
        check("035 event count", log_addr.size(), 2);
        if (log_addr.size() == 2) begin
            check("035 event0 addr", log_addr[0], 3);
            check("035 event0 src", log_src[0], 1);
            check("035 event1 addr", log_addr[1], 200);
            check("035 event1 src", log_src[1], 1);
        end
        probe();
        check("035 spike_cnt", cnt, 2);
        edge_step();

        // Stall with a busy queue, then release with ext_req held: sources alternate.
        drive(0,0,0,0,0,0,0,0);
        tick();
        drive(1,1,0,0,0,0,0,0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1,0,1,1,30 + i,0,0,0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1,0,0,0,0,1,8'h77,0);
            probe();
            check("037 stalled addr", evt_addr, 30);
            check("037 stalled src", evt_src, 1);
            check("037 stalled gnt", gnt, 0);
            edge_step();
        end
        log_addr.delete(); log_src.delete();
        for (int i = 0; i < 10; i++) begin
            drive(1,0,1,1,40 + i,1,8'h77,1);
            tick();
        end
        check("037 accepted count", log_src.size(), 10);
        for (int k = 1; k < log_src.size(); k++)
            check($sformatf("037 alternation %0d", k), log_src[k] ^ log_src[k-1], 1);
        if (log_addr.size() > 1) check("037 first ext addr", log_addr[1], 8'h77);
        drive(1,0,1,0,255,0,0,1);
        tick();
        drive(1,0,0,0,0,0,0,1);
        wait_done(30, "037 drain done");

        // Reset mid-scan with spikes queued: nothing queued may ever come out.
        drive(1,1,0,0,0,0,0,0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1,0,1,1,50 + i,0,0,0);
            tick();
        end
        drive(0,0,0,0,0,0,0,0);
        tick();
        drive(1,0,0,0,0,0,0,1);
        probe();
        check("038 evt_valid", evt_valid, 0);
        check("038 evt_addr", evt_addr, 0);
        check("038 evt_src", evt_src, 0);
        check("038 ext_gnt", gnt, 0);
        check("038 scan_busy", busy, 0);
        check("038 fifo_full", full, 0);
        check("038 overflow", ovf, 0);
        check("038 spike_cnt", cnt, 0);
        check("038 inference_done", done, 0);
        edge_step();
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 20; i++) begin
                tick();
                if (s_valid) seen++;
            end
            check("038 events after reset", seen, 0);
        end

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 499) != 0) ? 1 : 0,
                  ($urandom_range(0, 19) == 0) ? 1 : 0,
                  int'($urandom_range(0, 1)),
                  ($urandom_range(0, 2) == 0) ? 1 : 0,
                  ($urandom_range(0, 11) == 0) ? 255 : int'($urandom_range(0, 255)),
                  ($urandom_range(0, 2) == 0) ? 1 : 0,
                  int'($urandom_range(0, 255)),
                  ($urandom_range(0, 3) != 0) ? 1 : 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
